// File: rtl/button_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
// Shared definitions for the push-button event block.
//   state_t          : FSM state encodings (IDLE / PRESSED / LONG)
//   LONG_COUNT_DEF   : long-press threshold, 0.5 s at 50 MHz
//   REPEAT_COUNT_DEF : auto-repeat period, 0.1 s at 50 MHz
// ---------------------------------------------------------------------------
package button_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } state_t;

  localparam int LONG_COUNT_DEF   = 25_000_000;
  localparam int REPEAT_COUNT_DEF = 5_000_000;

endpackage : button_pkg

// File: rtl/button_event.sv
// ---------------------------------------------------------------------------
// button_event
// Turns a debounced button level into one-cycle event strobes.
//
// Parameters:
//   CNT_W        : hold-counter width
//   LONG_COUNT   : cycles held before a press counts as long
//   REPEAT_COUNT : auto-repeat period in cycles (used only with repeat built in)
//
// Ports:
//   clk          in  : single clock
//   reset_n      in  : synchronous active-low reset
//   db           in  : debounced button level, synchronous to clk
//   press_tick   out : strobe on press
//   release_tick out : strobe on every release
//   short_tick   out : strobe on release before the long threshold
//   long_tick    out : strobe when the long threshold is reached
//   repeat_tick  out : strobe once per auto-repeat period while long-held
//   held         out : high while the FSM is not idle
//
// Build option:
//   BUTTON_EVENT_REPEAT_EN : when defined, auto-repeat is active in LONG.
//                            When undefined, repeat_tick is tied low and the
//                            hold counter freezes in LONG.
// ---------------------------------------------------------------------------
module button_event
  import button_pkg::*;
#(
  parameter int CNT_W        = 26,
  parameter int LONG_COUNT   = LONG_COUNT_DEF,
  parameter int REPEAT_COUNT = REPEAT_COUNT_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic db,
  output logic press_tick,
  output logic release_tick,
  output logic short_tick,
  output logic long_tick,
  output logic repeat_tick,
  output logic held
);

  // Elaboration-time parameter sanity checks.
  if (LONG_COUNT < 2 || 64'(LONG_COUNT) >= (64'(1) << CNT_W)) begin : g_bad_long
    $error("button_event: LONG_COUNT out of range for CNT_W");
  end
  if (REPEAT_COUNT < 2 || 64'(REPEAT_COUNT) >= (64'(1) << CNT_W)) begin : g_bad_repeat
    $error("button_event: REPEAT_COUNT out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
`ifdef BUTTON_EVENT_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_TERM  = CNT_W'(REPEAT_COUNT - 1);
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic w_press;
  logic w_release;
  logic w_short;
  logic w_long;
  logic r_press_tick;
  logic r_release_tick;
  logic r_short_tick;
  logic r_long_tick;
`ifdef BUTTON_EVENT_REPEAT_EN
  logic w_repeat;
  logic r_repeat_tick;
`endif

  // Next-state, counter and strobe decode. Release is tested before the
  // threshold so that a release landing on the threshold edge wins.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press     = 1'b0;
    w_release   = 1'b0;
    w_short     = 1'b0;
    w_long      = 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
    w_repeat    = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        // Counter is frozen while idle and cleared on entry to PRESSED.
        if (db) begin
          w_state_nxt = ST_PRESSED;
          w_cnt_nxt   = '0;
          w_press     = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!db) begin
          w_state_nxt = ST_IDLE;
          w_release   = 1'b1;
          w_short     = 1'b1;
        end else if (r_cnt == LONG_TERM) begin
          w_state_nxt = ST_LONG;
          w_cnt_nxt   = '0;
          w_long      = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      ST_LONG: begin
        if (!db) begin
          w_state_nxt = ST_IDLE;
          w_release   = 1'b1;
        end
`ifdef BUTTON_EVENT_REPEAT_EN
        else if (r_cnt == REP_TERM) begin
          w_cnt_nxt   = '0;
          w_repeat    = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
`endif
      end
      default: begin
        // Unreachable encoding: recover silently.
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_press_tick   <= 1'b0;
      r_release_tick <= 1'b0;
      r_short_tick   <= 1'b0;
      r_long_tick    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_press_tick   <= w_press;
      r_release_tick <= w_release;
      r_short_tick   <= w_short;
      r_long_tick    <= w_long;
    end
  end

`ifdef BUTTON_EVENT_REPEAT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_repeat_tick <= 1'b0;
    end else begin
      r_repeat_tick <= w_repeat;
    end
  end
  assign repeat_tick = r_repeat_tick;
`else
  assign repeat_tick = 1'b0;
`endif

  assign press_tick   = r_press_tick;
  assign release_tick = r_release_tick;
  assign short_tick   = r_short_tick;
  assign long_tick    = r_long_tick;
  assign held         = (r_state != ST_IDLE);

endmodule : button_event

// File: tb/tb_button_event.sv
// ---------------------------------------------------------------------------
// tb_button_event
// Self-checking bench for button_event with LONG_COUNT=8, REPEAT_COUNT=4.
// The reference model tracks only "is the button considered pressed" and
// "how many edges it has been held", and derives every strobe from those.
// ---------------------------------------------------------------------------
module tb_button_event;

  localparam int LONG = 8;
  localparam int REP  = 4;
`ifdef BUTTON_EVENT_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic db = 1'b0;
  logic press_tick, release_tick, short_tick, long_tick, repeat_tick, held;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit         m_pressed = 1'b0;
  int         m_n = 0;
  logic [5:0] m_exp = '0;  // {press, release, short, long, repeat, held}

  button_event #(
    .CNT_W       (8),
    .LONG_COUNT  (LONG),
    .REPEAT_COUNT(REP)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .db          (db),
    .press_tick  (press_tick),
    .release_tick(release_tick),
    .short_tick  (short_tick),
    .long_tick   (long_tick),
    .repeat_tick (repeat_tick),
    .held        (held)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] obs();
    return {press_tick, release_tick, short_tick, long_tick, repeat_tick, held};
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, and leave
  // time 1 unit after the edge so outputs can be sampled.
  task automatic tick(input logic dbv, input logic rstv);
    logic p, r, s, l, rp;
    @(negedge clk);
    db      = dbv;
    reset_n = rstv;
    @(posedge clk);
    p = 0; r = 0; s = 0; l = 0; rp = 0;
    if (!rstv) begin
      m_pressed = 1'b0;
    end else if (!m_pressed) begin
      if (dbv) begin
        m_pressed = 1'b1;
        m_n = 0;
        p = 1;
      end
    end else if (dbv) begin
      m_n++;
      if (m_n == LONG) l = 1;
      else if (REP_EN && m_n > LONG && ((m_n - LONG) % REP) == 0) rp = 1;
    end else begin
      r = 1;
      s = (m_n < LONG);
      m_pressed = 1'b0;
    end
    m_exp = {p, r, s, l, rp, m_pressed};
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0);
      vectors++;
      if (obs() !== 6'b000000) begin
        miscompares++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, obs(), 6'b000000);
      end
    end
    tick(1'b1, 1'b1);
    vectors++;
    if (obs() !== 6'b100001) begin
      miscompares++;
      $display("FAIL reset_first_press got=%b exp=%b", obs(), 6'b100001);
    end
    tick(1'b0, 1'b1);
    vectors++;
    if (obs() !== m_exp) begin
      miscompares++;
      $display("FAIL reset_release got=%b exp=%b", obs(), m_exp);
    end
    tick(1'b0, 1'b1);
  endtask

  task automatic test_short_press();
    for (int i = 0; i <= 6; i++) begin
      tick(i < 5, 1'b1);
      vectors++;
      if (obs() !== m_exp) begin
        miscompares++;
        $display("FAIL short_press E%0d got=%b exp=%b", i, obs(), m_exp);
      end
    end
  endtask

  task automatic test_long_press();
    int longs = 0, reps = 0;
    for (int i = 0; i <= 21; i++) begin
      tick(i < 20, 1'b1);
      longs += long_tick;
      reps  += repeat_tick;
      vectors++;
      if (obs() !== m_exp) begin
        miscompares++;
        $display("FAIL long_press E%0d got=%b exp=%b", i, obs(), m_exp);
      end
    end
    vectors++;
    if (longs !== 1 || reps !== (REP_EN ? 2 : 0)) begin
      miscompares++;
      $display("FAIL long_press_counts got long=%0d rep=%0d exp long=1 rep=%0d",
               longs, reps, REP_EN ? 2 : 0);
    end
  endtask

  task automatic test_release_on_threshold();
    for (int i = 0; i <= 9; i++) begin
      tick(i < LONG, 1'b1);
      vectors++;
      if (obs() !== m_exp) begin
        miscompares++;
        $display("FAIL threshold_release E%0d got=%b exp=%b", i, obs(), m_exp);
      end
    end
  endtask

  task automatic test_hold_30();
    int longs = 0, reps = 0;
    for (int i = 0; i <= 31; i++) begin
      tick(i < 30, 1'b1);
      longs += long_tick;
      reps  += repeat_tick;
      vectors++;
      if (obs() !== m_exp) begin
        miscompares++;
        $display("FAIL hold30 E%0d got=%b exp=%b", i, obs(), m_exp);
      end
    end
    vectors++;
    if (longs !== 1 || reps !== (REP_EN ? 5 : 0)) begin
      miscompares++;
      $display("FAIL hold30_counts got long=%0d rep=%0d exp long=1 rep=%0d",
               longs, reps, REP_EN ? 5 : 0);
    end
  endtask

  task automatic test_back_to_back();
    // Single-cycle presses separated by single idle cycles.
    for (int i = 0; i < 10; i++) begin
      tick(i[0] == 1'b0, 1'b1);
      vectors++;
      if (obs() !== m_exp) begin
        miscompares++;
        $display("FAIL back_to_back cyc=%0d got=%b exp=%b", i, obs(), m_exp);
      end
    end
  endtask

  task automatic test_reset_mid_press();
    for (int i = 0; i <= 5; i++) tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);   // reset sampled at E6
    vectors++;
    if (obs() !== 6'b000000) begin
      miscompares++;
      $display("FAIL reset_mid_assert got=%b exp=%b", obs(), 6'b000000);
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b1);
      vectors++;
      if (obs() !== 6'b000000) begin
        miscompares++;
        $display("FAIL reset_mid_after cyc=%0d got=%b exp=%b", i, obs(), 6'b000000);
      end
    end
    for (int i = 0; i <= 10; i++) begin
      tick(i < 10, 1'b1);
      vectors++;
      if (long_tick !== (i == LONG) || obs() !== m_exp) begin
        miscompares++;
        $display("FAIL reset_mid_repress E%0d got=%b exp=%b", i, obs(), m_exp);
      end
    end
  endtask

  task automatic test_random();
    logic lvl = 1'b0;
    int   run = 0;
    for (int i = 0; i < 3000; i++) begin
      logic rst;
      if (run == 0) begin
        lvl = ~lvl;
        run = $urandom_range(1, 30);
      end
      run--;
      rst = ($urandom_range(0, 199) != 0);
      tick(lvl, rst);
      vectors++;
      if (obs() !== m_exp
          || (int'(press_tick) + int'(long_tick) + int'(repeat_tick)) > 1
          || (short_tick && !release_tick)) begin
        miscompares++;
        $display("FAIL random cyc=%0d db=%b rst_n=%b got=%b exp=%b",
                 i, lvl, rst, obs(), m_exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_long_press();
    test_release_on_threshold();
    test_hold_30();
    test_back_to_back();
    test_reset_mid_press();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_button_event
